// File: rtl/uart_tx_sequencer_if.sv
// Producer-side byte stream plus UART component bus for the Tx sequencer.
// Also carries the flush and level signals.
interface uart_tx_sequencer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LevelW = $clog2(DEPTH) + 1;

  logic              push_valid;
  logic [7:0]        push_data;
  logic              push_ready;
  logic              flush;
  logic [LevelW-1:0] level;
  logic              uart_cs;
  logic              uart_rd;
  logic              uart_wr;
  logic [2:0]        uart_addr;
  logic [7:0]        uart_in_data;
  logic [7:0]        uart_out_data;
  logic              busy;

  modport master (
    output push_valid, push_data, flush, uart_out_data,
    input  push_ready, level, uart_cs, uart_rd, uart_wr, uart_addr, uart_in_data, busy
  );

  modport slave (
    input  push_valid, push_data, flush, uart_out_data,
    output push_ready, level, uart_cs, uart_rd, uart_wr, uart_addr, uart_in_data, busy
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Byte FIFO that drains into a bus-attached UART.
// Each byte is written only after polling the control register until the busy bit clears.
module uart_tx_sequencer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned BUSY_BIT     = 0
) (
  input  logic               clock,
  input  logic               reset,
  uart_tx_sequencer_if.slave bus
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  localparam logic [LevelW-1:0] LevelFull = LevelW'(DEPTH);
  localparam logic [3:0]        SetupLast = 4'(SETUP_CYCLES - 1);
  localparam logic [2:0]        BusyIdx   = BUSY_BIT[2:0];
  localparam logic [2:0]        AddrCtrl  = 3'd0;
  localparam logic [2:0]        AddrTx    = 3'd2;

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StPollSetup  = 3'd1;
  localparam logic [2:0] StPollSample = 3'd2;
  localparam logic [2:0] StWrSetup    = 3'd3;
  localparam logic [2:0] StWrStrobe   = 3'd4;
  localparam logic [2:0] StWrRelease  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [7:0]        data_q;
  logic [7:0]        mem [DEPTH];

  logic push_ok;
  logic pop;

  assign bus.push_ready   = (level_q != LevelFull);
  assign bus.level        = level_q;
  assign bus.uart_in_data = data_q;
  assign bus.busy         = (state_q != StIdle);

  assign push_ok = bus.push_valid && bus.push_ready && !bus.flush;
  // A flushed queue can leave POLL_SAMPLE with nothing to pop; it falls back to idle.
  assign pop     = (state_q == StPollSample) && !bus.uart_out_data[BusyIdx] && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop})
        2'b10:   level_d = level_q + LevelW'(1);
        2'b01:   level_d = level_q - LevelW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle:       if (level_q != '0) state_d = StPollSetup;
      StPollSetup:  state_d = StPollSample;
      StPollSample: begin
        if (bus.uart_out_data[BusyIdx]) begin
          state_d = StPollSetup;
        end else if (level_q != '0) begin
          state_d = StWrSetup;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StWrSetup: begin
        if (cnt_q == SetupLast) state_d = StWrStrobe;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      StWrStrobe:  state_d = StWrRelease;
      StWrRelease: state_d = (level_q != '0) ? StPollSetup : StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Strobes decode straight from state so an asynchronous reset releases them immediately.
  always_comb begin
    bus.uart_cs   = 1'b1;
    bus.uart_rd   = 1'b1;
    bus.uart_wr   = 1'b1;
    bus.uart_addr = AddrCtrl;
    case (state_q)
      StPollSetup, StPollSample: begin
        bus.uart_cs = 1'b0;
        bus.uart_rd = 1'b0;
      end
      StWrSetup: begin
        bus.uart_cs   = 1'b0;
        bus.uart_addr = AddrTx;
      end
      StWrStrobe: begin
        bus.uart_cs   = 1'b0;
        bus.uart_wr   = 1'b0;
        bus.uart_addr = AddrTx;
      end
      StWrRelease: bus.uart_addr = AddrTx;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (pop) data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= bus.push_data;
  end

endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter SETUP_CYCLES, default 2, meaning cycles cs/addr/in_data are held before wr strobe; range 1..15.
REQ-003 SHALL have parameter BUSY_BIT, default 0, meaning control-register bit that is 1 while the UART transmitter is busy.
REQ-004 SHALL have port clock, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port push_valid, input, 1, producer offers push_data.
REQ-007 SHALL have port push_data, input, 8, byte to transmit.
REQ-008 SHALL have port push_ready, output, 1, FIFO can accept a byte.
REQ-009 SHALL have port flush, input, 1, discards all queued bytes.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1, queued byte count.
REQ-011 SHALL have ports uart_cs, uart_rd, uart_wr, each output, 1, active-low UART component bus strobes.
REQ-012 SHALL have port uart_addr, output, 3: 0 = control, 2 = Tx buffer.
REQ-013 SHALL have port uart_in_data, output, 8, byte written to the UART.
REQ-014 SHALL have port uart_out_data, input, 8, UART read data.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL accept a byte on a rising clock edge when push_valid and push_ready are both 1.
REQ-017 SHALL drive push_ready = 1 iff level < DEPTH.
REQ-018 SHALL, on simultaneous push and pop, leave level unchanged and preserve byte order.
REQ-019 SHALL wrap read and write pointers modulo DEPTH; full and empty SHALL be distinguished by level, not by pointer equality.
REQ-020 SHALL run FSM states IDLE, POLL_SETUP, POLL_SAMPLE, WR_SETUP, WR_STROBE, WR_RELEASE.
REQ-021 IDLE: all strobes high; go to POLL_SETUP when level > 0.
REQ-022 POLL_SETUP: cs=0, rd=0, addr=0 for one cycle; then go to POLL_SAMPLE.
REQ-023 POLL_SAMPLE: cs=0, rd=0; sample uart_out_data[BUSY_BIT]; if 1, go to POLL_SETUP; if 0, pop the FIFO head into uart_in_data and go to WR_SETUP.
REQ-024 WR_SETUP: cs=0, rd=1, wr=1, addr=2, uart_in_data stable for exactly SETUP_CYCLES cycles (internal counter); then go to WR_STROBE.
REQ-025 WR_STROBE: wr=0 for exactly one cycle, cs=0, addr and data stable; then go to WR_RELEASE.
REQ-026 WR_RELEASE: cs=1, wr=1 for one cycle; then go to POLL_SETUP if level > 0, else IDLE.
REQ-027 SHALL never assert rd=0 and wr=0 in the same cycle, and SHALL never assert either while cs=1.
REQ-028 flush SHALL zero level and pointers next edge; a push in the same cycle as flush SHALL be dropped.
REQ-029 flush SHALL NOT abort a byte already popped; it completes through WR_RELEASE.
REQ-030 Best-case latency, push into an empty idle block to wr=0, SHALL be SETUP_CYCLES+4 cycles.

Reset
REQ-031 While reset=1: state=IDLE, level=0, pointers=0, uart_cs=uart_rd=uart_wr=1, uart_addr=0, uart_in_data=0, push_ready=1, busy=0.
REQ-032 Reset asserted mid-operation SHALL abort immediately, including mid-WR_STROBE: wr and cs return high asynchronously and queued data is lost.
REQ-033 After reset deasserts, first FSM activity SHALL occur on the first clock edge after deassertion.

Verification
REQ-034 Push 0x4F into an idle block with out_data[0]=0 -> exactly one wr=0 pulse with addr=2, data=0x4F, at cycle SETUP_CYCLES+4.
REQ-035 Push 0x4F,0x6B with busy bit held 1 for 10 cycles -> polling repeats, no wr until busy=0, then 0x4F before 0x6B.
REQ-036 Push DEPTH+1 bytes back-to-back with busy=1 -> push_ready=0 after DEPTH bytes, level=DEPTH, extra byte not accepted.
REQ-037 Fill 3 bytes, assert flush during WR_SETUP -> current byte written, level=0, no further writes.
REQ-038 Assert reset during WR_STROBE -> uart_wr=1 and uart_cs=1 without a clock edge, level=0, busy=0.
REQ-039 Random push/pop over 1000 bytes with DEPTH=4 and random busy -> output order equals input order, no rd/wr overlap.
